// File: rtl/wave_pkg.sv
// Shared types and screen geometry for the waveform capture/render block.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package wave_pkg;

  typedef enum logic [1:0] {
    ARM  = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int SCREEN_H = 1024;
  localparam int SCREEN_W = 1280;
  localparam int ROW_W    = 10;

  // Full-scale sample maps to the top row: row = 1023 - sample[11:2],
  // which for a 10-bit field is simply the bitwise inverse.
  function automatic logic [ROW_W-1:0] sample_to_row(input logic [11:0] sample);
    return ~sample[11:2];
  endfunction

endpackage

// File: rtl/wave_sample_ram.sv
// Simple dual-port sample store: one write port, one registered read port.
// Latency: read data valid 1 cycle after rd_addr.
// Backpressure: none; writes and reads are accepted every cycle.
module wave_sample_ram #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 10
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_dat,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_dat
);

  // The bank select is the top address bit, so each bank owns a
  // power-of-two half of the array and the store maps onto block RAM.
  logic [DATA_W-1:0] mem_q [2**ADDR_W];

  // Write port: no reset, contents survive a block reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_dat;
    end
  end

  // Registered read port.
  always_ff @(posedge clk) begin
    rd_dat <= mem_q[rd_addr];
  end

endmodule

// File: rtl/waveform_capture_render.sv
// Captures a screen-width of audio samples into a double-buffered store and draws them as a trace.
// Latency: colour outputs follow VGA coordinates by exactly 2 CLK_VGA cycles.
// Backpressure: none; SAMPLE_EN strobes are never stalled, strobes arriving in DONE are dropped.
module waveform_capture_render #(
  parameter int          NUM_SAMPLES  = 1280,
  parameter logic [11:0] TRIG_LEVEL   = 12'd2048,
  parameter int          TRIG_TIMEOUT = 4000,
  parameter logic [11:0] WAVE_COLOUR  = 12'h0F0
) (
  input  logic        CLK_VGA,
  input  logic        RESET,
  input  logic        SAMPLE_EN,
  input  logic [11:0] MIC_IN,
  input  logic        Trigger_En,
  input  logic        Freeze,
  input  logic [11:0] VGA_HORZ_COORD,
  input  logic [11:0] VGA_VERT_COORD,
  output logic [3:0]  VGA_RED_WAVEFORM,
  output logic [3:0]  VGA_GREEN_WAVEFORM,
  output logic [3:0]  VGA_BLUE_WAVEFORM,
  output logic        Capture_Busy
);

  import wave_pkg::*;

  localparam int IDX_W = (NUM_SAMPLES > 1) ? $clog2(NUM_SAMPLES) : 1;
  localparam int TMO_W = $clog2(TRIG_TIMEOUT + 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_SAMPLES - 1);
  localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(TRIG_TIMEOUT);

  // Capture side state.
  state_t             state_q, state_d;
  logic [IDX_W-1:0]   wr_idx_q, wr_idx_d;
  logic [TMO_W-1:0]   tmo_cnt_q, tmo_cnt_d;
  logic [11:0]        prev_sample_q, prev_sample_d;
  logic               disp_sel_q, disp_sel_d;
  logic               disp_valid_q, disp_valid_d;

  logic               wr_en;
  logic [IDX_W:0]     wr_addr;
  logic [ROW_W-1:0]   wr_dat;
  logic               trig_hit;

  // Render side pipeline.
  logic [IDX_W:0]     rd_addr;
  logic [ROW_W-1:0]   rd_dat;
  logic [11:0]        x_p1_q, x_p1_d;
  logic [11:0]        y_p1_q, y_p1_d;
  logic [ROW_W-1:0]   prev_col_q, prev_col_d;
  logic [11:0]        colour_q, colour_d;

  // Capture FSM: arm/trigger, fill the write bank, then wait for vblank to swap.
  always_comb begin
    state_d       = state_q;
    wr_idx_d      = wr_idx_q;
    tmo_cnt_d     = tmo_cnt_q;
    prev_sample_d = prev_sample_q;
    disp_sel_d    = disp_sel_q;
    disp_valid_d  = disp_valid_q;
    wr_en         = 1'b0;
    wr_addr       = {~disp_sel_q, wr_idx_q};
    wr_dat        = sample_to_row(MIC_IN);
    trig_hit      = (prev_sample_q < TRIG_LEVEL) && (MIC_IN >= TRIG_LEVEL);

    if (SAMPLE_EN) begin
      prev_sample_d = MIC_IN;
    end

    case (state_q)
      ARM: begin
        if (SAMPLE_EN) begin
          if (!Trigger_En || trig_hit || (tmo_cnt_q == TMO_LIMIT)) begin
            // wr_idx is 0 here, so the triggering sample lands at index 0.
            wr_en    = 1'b1;
            wr_idx_d = wr_idx_q + IDX_W'(1);
            state_d  = FILL;
          end else begin
            tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
          end
        end
      end
      FILL: begin
        if (SAMPLE_EN) begin
          wr_en = 1'b1;
          if (wr_idx_q == LAST_IDX) begin
            state_d = DONE;
          end else begin
            wr_idx_d = wr_idx_q + IDX_W'(1);
          end
        end
      end
      DONE: begin
        // Swap only in vertical blank so no visible frame mixes banks.
        if ((VGA_VERT_COORD >= 12'(SCREEN_H)) && !Freeze) begin
          disp_sel_d   = ~disp_sel_q;
          disp_valid_d = 1'b1;
          wr_idx_d     = '0;
          tmo_cnt_d    = '0;
          state_d      = ARM;
        end
      end
      default: state_d = ARM;
    endcase
  end

  // Capture state registers with synchronous reset.
  always_ff @(posedge CLK_VGA) begin
    if (RESET) begin
      state_q       <= ARM;
      wr_idx_q      <= '0;
      tmo_cnt_q     <= '0;
      prev_sample_q <= '0;
      disp_sel_q    <= 1'b0;
      disp_valid_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_idx_q      <= wr_idx_d;
      tmo_cnt_q     <= tmo_cnt_d;
      prev_sample_q <= prev_sample_d;
      disp_sel_q    <= disp_sel_d;
      disp_valid_q  <= disp_valid_d;
    end
  end

  assign Capture_Busy = (state_q == ARM) || (state_q == FILL);

  assign rd_addr = {disp_sel_q, VGA_HORZ_COORD[IDX_W-1:0]};

  wave_sample_ram #(
    .ADDR_W (IDX_W + 1),
    .DATA_W (ROW_W)
  ) u_ram (
    .clk     (CLK_VGA),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_dat  (wr_dat),
    .rd_addr (rd_addr),
    .rd_dat  (rd_dat)
  );

  // Render compare: the current column's row arrives from RAM, the previous
  // column's row is the last read held one more cycle (x steps by one per cycle).
  always_comb begin
    logic [ROW_W-1:0] lo;
    logic [ROW_W-1:0] hi;
    logic [ROW_W-1:0] row;
    logic             hit;
    logic             lit;

    x_p1_d     = VGA_HORZ_COORD;
    y_p1_d     = VGA_VERT_COORD;
    prev_col_d = rd_dat;

    lo  = (prev_col_q < rd_dat) ? prev_col_q : rd_dat;
    hi  = (prev_col_q < rd_dat) ? rd_dat : prev_col_q;
    row = y_p1_q[ROW_W-1:0];
    if (x_p1_q == 12'd0) begin
      hit = (row == rd_dat);
    end else begin
      hit = (row >= lo) && (row <= hi);
    end
    lit = disp_valid_q && (x_p1_q < 12'(NUM_SAMPLES)) &&
          (y_p1_q < 12'(SCREEN_H)) && hit;
    colour_d = lit ? WAVE_COLOUR : 12'h000;
  end

  // Render pipeline registers; colour is forced dark while in reset.
  always_ff @(posedge CLK_VGA) begin
    if (RESET) begin
      x_p1_q     <= '0;
      y_p1_q     <= '0;
      prev_col_q <= '0;
      colour_q   <= '0;
    end else begin
      x_p1_q     <= x_p1_d;
      y_p1_q     <= y_p1_d;
      prev_col_q <= prev_col_d;
      colour_q   <= colour_d;
    end
  end

  assign VGA_RED_WAVEFORM   = colour_q[11:8];
  assign VGA_GREEN_WAVEFORM = colour_q[7:4];
  assign VGA_BLUE_WAVEFORM  = colour_q[3:0];

endmodule

// File: tb/tb_waveform_capture_render.sv
// Directed bench for waveform_capture_render: capture modes, swap timing, pixel rendering.
// Latency: checks colour exactly 2 cycles after coordinates.
// Backpressure: n/a.
module tb_waveform_capture_render;

  localparam int NS = 1280;

  logic        CLK_VGA = 1'b0;
  logic        RESET;
  logic        SAMPLE_EN;
  logic [11:0] MIC_IN;
  logic        Trigger_En;
  logic        Freeze;
  logic [11:0] VGA_HORZ_COORD;
  logic [11:0] VGA_VERT_COORD;
  logic [3:0]  red_w, green_w, blue_w;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;

  int stim     [0:5399];
  int cap_row  [0:NS-1];
  int disp_row [0:NS-1];
  bit disp_ok = 1'b0;
  logic [11:0] c;

  always #5 CLK_VGA = ~CLK_VGA;

  waveform_capture_render dut (
    .CLK_VGA            (CLK_VGA),
    .RESET              (RESET),
    .SAMPLE_EN          (SAMPLE_EN),
    .MIC_IN             (MIC_IN),
    .Trigger_En         (Trigger_En),
    .Freeze             (Freeze),
    .VGA_HORZ_COORD     (VGA_HORZ_COORD),
    .VGA_VERT_COORD     (VGA_VERT_COORD),
    .VGA_RED_WAVEFORM   (red_w),
    .VGA_GREEN_WAVEFORM (green_w),
    .VGA_BLUE_WAVEFORM  (blue_w),
    .Capture_Busy       (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int row_of(input int v);
    return 1023 - ((v >> 2) & 1023);
  endfunction

  function automatic logic [11:0] exp_pix(input int x, input int y);
    int lo, hi;
    bit lit;
    if (!disp_ok || x >= NS || y >= 1024) return 12'h000;
    if (x == 0) begin
      lit = (y == disp_row[0]);
    end else begin
      lo  = (disp_row[x-1] < disp_row[x]) ? disp_row[x-1] : disp_row[x];
      hi  = (disp_row[x-1] < disp_row[x]) ? disp_row[x] : disp_row[x-1];
      lit = (y >= lo) && (y <= hi);
    end
    return lit ? 12'h0F0 : 12'h000;
  endfunction

  task automatic tick();
    @(posedge CLK_VGA);
    #1;
  endtask

  task automatic strobe(input int v);
    SAMPLE_EN = 1'b1;
    MIC_IN    = 12'(v);
    tick();
    SAMPLE_EN = 1'b0;
  endtask

  // Drives stim[0..n-1]; busy must still be high before the last strobe and low after it.
  task automatic run_capture(input int n, input string tag);
    for (int i = 0; i < n - 1; i++) strobe(stim[i]);
    check({tag, "_busy_before_last"}, 32'(busy), 32'd1);
    strobe(stim[n-1]);
    check({tag, "_busy_after_last"}, 32'(busy), 32'd0);
  endtask

  task automatic vblank();
    VGA_VERT_COORD = 12'd1024;
    tick();
    VGA_VERT_COORD = 12'd0;
  endtask

  task automatic swap_model();
    disp_row = cap_row;
    disp_ok  = 1'b1;
  endtask

  // Presents x-1 then x on row y and returns the colour 2 cycles after x.
  task automatic probe(input int x, input int y, output logic [11:0] col);
    VGA_HORZ_COORD = 12'((x > 0) ? x - 1 : 0);
    VGA_VERT_COORD = 12'(y);
    tick();
    VGA_HORZ_COORD = 12'(x);
    tick();
    tick();
    col = {red_w, green_w, blue_w};
    VGA_HORZ_COORD = 12'd0;
    VGA_VERT_COORD = 12'd0;
  endtask

  // Streams columns x0..x0+n-1 on row y, one per cycle, checking each against the model.
  task automatic scan_row(input int y, input int x0, input int n, input string tag);
    VGA_VERT_COORD = 12'(y);
    VGA_HORZ_COORD = 12'((x0 > 0) ? x0 - 1 : 0);
    for (int k = 1; k <= n + 2; k++) begin
      tick();
      if (k >= 3) check(tag, 32'({red_w, green_w, blue_w}), 32'(exp_pix(x0 + k - 3, y)));
      if (k <= n) VGA_HORZ_COORD = 12'(x0 + k - 1);
    end
    VGA_HORZ_COORD = 12'd0;
    VGA_VERT_COORD = 12'd0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    RESET = 1'b1; SAMPLE_EN = 1'b0; MIC_IN = '0; Trigger_En = 1'b0; Freeze = 1'b0;
    VGA_HORZ_COORD = '0; VGA_VERT_COORD = '0;
    repeat (3) tick();
    check("rst_colour", 32'({red_w, green_w, blue_w}), 32'h0);
    check("rst_busy", 32'(busy), 32'd1);
    RESET = 1'b0;
    tick();

    // Free-run ramp capture.
    for (int i = 0; i < NS; i++) begin
      stim[i]    = i * 3;
      cap_row[i] = row_of(i * 3);
    end
    run_capture(NS, "ramp");
    scan_row(543, 636, 8, "ramp_dark_before_swap");
    vblank();
    swap_model();
    check("ramp_busy_after_swap", 32'(busy), 32'd1);
    probe(640, 543, c); check("ramp_x640_y543", 32'(c), 32'h0F0);
    probe(640, 544, c); check("ramp_x640_y544", 32'(c), 32'h0F0);
    probe(640, 545, c); check("ramp_x640_y545", 32'(c), 32'h000);
    probe(640, 542, c); check("ramp_x640_y542", 32'(c), 32'h000);
    scan_row(543, 636, 8, "ramp_scan543");
    scan_row(1023, 0, 4, "ramp_col0");

    // Triggered capture on a sine crossing 2048 upward at sample 37.
    Trigger_En = 1'b1;
    for (int k = 0; k < 37 + NS; k++) begin
      stim[k] = 2048 + $rtoi(1500.0 * $sin(2.0 * 3.14159265358979 * real'(k - 37) / 148.0));
    end
    for (int i = 0; i < NS; i++) cap_row[i] = row_of(stim[37 + i]);
    run_capture(37 + NS, "sine");
    vblank();
    swap_model();
    probe(0, 511, c); check("sine_s0_row511", 32'(c), 32'h0F0);
    probe(0, 527, c); check("sine_s0_not_sample36", 32'(c), 32'h000);
    probe(0, 510, c); check("sine_s0_row510", 32'(c), 32'h000);
    scan_row(511, 0, 6, "sine_scan511");

    // Constant level never triggers: timeout forces FILL at strobe 4001.
    for (int i = 0; i < 4000 + NS; i++) stim[i] = 100;
    for (int i = 0; i < NS; i++) cap_row[i] = 998;
    run_capture(4000 + NS, "tmo");
    vblank();
    swap_model();
    probe(700, 998, c); check("tmo_flat_998", 32'(c), 32'h0F0);
    probe(700, 997, c); check("tmo_flat_997", 32'(c), 32'h000);
    scan_row(998, 1276, 8, "tmo_right_edge");

    // Freeze holds the displayed bank through repeated sample bursts and vblanks.
    Trigger_En = 1'b0;
    Freeze     = 1'b1;
    for (int i = 0; i < NS; i++) begin
      stim[i]    = 400;
      cap_row[i] = 923;
    end
    run_capture(NS, "frz_a");
    for (int rep = 0; rep < 3; rep++) begin
      for (int i = 0; i < NS; i++) strobe(800 + rep * 1000);
      vblank();
      check("frz_busy_held", 32'(busy), 32'd0);
      probe(700, 998, c); check("frz_old_bank_lit", 32'(c), 32'h0F0);
      probe(700, 923, c); check("frz_new_bank_hidden", 32'(c), 32'h000);
    end
    Freeze = 1'b0;
    VGA_VERT_COORD = 12'd1023;
    tick();
    VGA_VERT_COORD = 12'd0;
    check("frz_no_swap_at_1023", 32'(busy), 32'd0);
    vblank();
    swap_model();
    check("frz_swap_busy", 32'(busy), 32'd1);
    probe(700, 923, c); check("frz_swap_new_lit", 32'(c), 32'h0F0);
    probe(700, 998, c); check("frz_swap_old_gone", 32'(c), 32'h000);

    // Alternating rows 100 / 200.
    for (int i = 0; i < NS; i++) begin
      stim[i]    = (i % 2 == 0) ? 3692 : 3292;
      cap_row[i] = (i % 2 == 0) ? 100 : 200;
    end
    run_capture(NS, "adj");
    vblank();
    swap_model();
    probe(11, 100, c); check("adj_y100", 32'(c), 32'h0F0);
    probe(11, 200, c); check("adj_y200", 32'(c), 32'h0F0);
    probe(11, 99, c);  check("adj_y99", 32'(c), 32'h000);
    probe(11, 201, c); check("adj_y201", 32'(c), 32'h000);
    probe(0, 100, c);  check("adj_col0_y100", 32'(c), 32'h0F0);
    probe(0, 150, c);  check("adj_col0_y150", 32'(c), 32'h000);
    probe(1300, 150, c); check("adj_x1300_dark", 32'(c), 32'h000);
    VGA_HORZ_COORD = 12'd9;  VGA_VERT_COORD = 12'd1023;
    tick();
    VGA_HORZ_COORD = 12'd10; VGA_VERT_COORD = 12'd150;
    tick();
    check("adj_lat_1cyc_dark", 32'({red_w, green_w, blue_w}), 32'h000);
    tick();
    check("adj_lat_2cyc_red", 32'(red_w), 32'h0);
    check("adj_lat_2cyc_green", 32'(green_w), 32'hF);
    check("adj_lat_2cyc_blue", 32'(blue_w), 32'h0);
    VGA_HORZ_COORD = 12'd0; VGA_VERT_COORD = 12'd0;
    scan_row(150, 1276, 6, "adj_right_edge");
    scan_row(100, 0, 5, "adj_scan100");

    // Reset in the middle of a capture abandons it and blanks the display.
    for (int i = 0; i < 600; i++) strobe(3000);
    VGA_HORZ_COORD = 12'd11; VGA_VERT_COORD = 12'd150;
    RESET = 1'b1;
    tick();
    tick();
    check("rst_mid_colour", 32'({red_w, green_w, blue_w}), 32'h0);
    check("rst_mid_busy", 32'(busy), 32'd1);
    RESET = 1'b0;
    disp_ok = 1'b0;
    probe(11, 150, c); check("rst_dark_after", 32'(c), 32'h000);
    for (int i = 0; i < NS; i++) begin
      stim[i]    = 2000;
      cap_row[i] = 523;
    end
    run_capture(NS, "post_rst");
    probe(11, 523, c); check("post_rst_dark_before_swap", 32'(c), 32'h000);
    vblank();
    swap_model();
    probe(11, 523, c); check("post_rst_lit", 32'(c), 32'h0F0);
    probe(11, 522, c); check("post_rst_y522", 32'(c), 32'h000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/waveform_capture_render.md
WAVEFORM_CAPTURE_RENDER -- requirements
Module: waveform_capture_render

Interface
REQ-001 The block SHALL have parameter NUM_SAMPLES, default 1280: displayed columns and samples per capture.
REQ-002 The block SHALL have parameter TRIG_LEVEL, default 12'd2048: rising-edge trigger threshold.
REQ-003 The block SHALL have parameter TRIG_TIMEOUT, default 4000: samples waited in ARM before auto-fill.
REQ-004 The block SHALL have parameter WAVE_COLOUR, default 12'h0F0: RGB444 colour of lit pixels.
REQ-005 The block SHALL have port CLK_VGA, input, width 1: the only clock, 108 MHz pixel clock.
REQ-006 The block SHALL have port RESET, input, width 1: reset, synchronous and active-high.
REQ-007 The block SHALL have port SAMPLE_EN, input, width 1: one-cycle strobe per audio sample (20 kHz).
REQ-008 The block SHALL have port MIC_IN, input, width 12: unsigned sample, valid when SAMPLE_EN=1.
REQ-009 The block SHALL have port Trigger_En, input, width 1: 1 = triggered capture; 0 = free-run capture.
REQ-010 The block SHALL have port Freeze, input, width 1: 1 = inhibit display buffer swap.
REQ-011 The block SHALL have port VGA_HORZ_COORD, input, width 12: current pixel column.
REQ-012 The block SHALL have port VGA_VERT_COORD, input, width 12: current pixel row.
REQ-013 The block SHALL have ports VGA_RED_WAVEFORM, VGA_GREEN_WAVEFORM and VGA_BLUE_WAVEFORM, output, width 4 each: waveform pixel colour fed to the channel combiner.
REQ-014 The block SHALL have port Capture_Busy, output, width 1: high while state is ARM or FILL.

Function
REQ-015 Storage SHALL be two banks of NUM_SAMPLES x 10-bit display rows, one write bank and one display bank, selected by register disp_sel.
REQ-016 Stored row SHALL be 1023 - MIC_IN[11:2] (range 0..1023, top row = full scale).
REQ-017 The FSM SHALL have states ARM, FILL and DONE.
REQ-018 In ARM, on each SAMPLE_EN, the block SHALL enter FILL and write the sample at index 0 if Trigger_En=0, or if prev_sample < TRIG_LEVEL and MIC_IN >= TRIG_LEVEL.
REQ-019 In ARM, after TRIG_TIMEOUT SAMPLE_EN strobes without a trigger, the block SHALL enter FILL on the next strobe regardless of level.
REQ-020 prev_sample SHALL update on every SAMPLE_EN in all states.
REQ-021 In FILL, each SAMPLE_EN SHALL write the write bank at index wr_idx, then increment wr_idx.
REQ-022 The write at index NUM_SAMPLES-1 SHALL move the FSM to DONE, with no wrap.
REQ-023 In DONE, SAMPLE_EN writes SHALL be ignored.
REQ-024 In DONE, on the first cycle with VGA_VERT_COORD >= 1024 and Freeze=0, the block SHALL toggle disp_sel, set disp_valid=1, clear wr_idx and the timeout counter, and return to ARM.
REQ-025 While Freeze=1, the FSM SHALL remain in DONE and the display SHALL show the same bank indefinitely.
REQ-026 Pixel (x,y) SHALL be lit when x < NUM_SAMPLES, y < 1024, disp_valid=1, and min(s[x-1],s[x]) <= y <= max(s[x-1],s[x]), where s is the display bank.
REQ-027 For column x=0, pixel (0,y) SHALL be lit only when y == s[0].
REQ-028 Lit pixels SHALL output WAVE_COLOUR split as [11:8] red, [7:4] green, [3:0] blue; all other pixels SHALL output 0.
REQ-029 Render latency SHALL be exactly 2 CLK_VGA cycles from coordinates to colour outputs (1 RAM read, 1 compare/register).
REQ-030 s[x-1] SHALL come from a register holding the previous column's read, valid because x increments by 1 per cycle within a line.
REQ-031 A swap SHALL take effect only in vertical blank, so no visible frame mixes banks.

Reset
REQ-032 While RESET=1, the block SHALL set state=ARM, wr_idx=0, the timeout counter to 0, prev_sample=0, disp_sel=0, disp_valid=0 and all colour outputs to 0.
REQ-033 RESET SHALL not clear RAM contents.
REQ-034 RESET asserted mid-FILL or mid-frame SHALL abandon the capture; outputs SHALL stay 0 until the first post-reset swap.

Structure
REQ-035 Shared package wave_pkg SHALL hold the state encoding (ARM=2'd0, FILL=2'd1, DONE=2'd2), SCREEN_H=1024, SCREEN_W=1280 and ROW_W=10.
REQ-036 Sub-module wave_sample_ram SHALL be a simple dual-port RAM (one write port, one read port) of 2*NUM_SAMPLES x 10 bits with 1-cycle read latency.
REQ-037 The bank bit SHALL be the address MSB of wave_sample_ram, inferring block RAM.

Verification
REQ-038 Trigger_En=0 with a 1280-sample ramp, then vblank → Capture_Busy falls after 1280 strobes; after the swap, pixel (640,y) is lit for y = 1023 - ramp[640][11:2].
REQ-039 Trigger_En=1 with a sine crossing 2048 upward at sample 37 → s[0] equals sample 37's row; samples before 37 are never stored.
REQ-040 Trigger_En=1 with constant MIC_IN=100 → FILL starts at strobe 4001 (timeout); the display shows a flat line at row 998.
REQ-041 Freeze=1 held across 3 completed captures → disp_sel unchanged and outputs stable; on Freeze=0, the swap occurs at the next VGA_VERT_COORD=1024.
REQ-042 Adjacent samples at rows 100 and 200 → column x is lit for rows 100..200 inclusive, colour 0/F/0 appears 2 cycles after the coordinates, and x=1300 is dark.
REQ-043 RESET pulsed at wr_idx=600 → all outputs 0, state ARM, wr_idx 0; no pixel is lit until a full capture and swap complete.
